// File: rtl/ysyx_22040228div_issue_pkg.sv
// Shared opcodes, FSM state encoding and opcode predicates for the divide issue path.
// Optional result cache is enabled with YSYX22040228_DIV_RESULT_CACHE_EN (see ysyx_22040228div_issue).
package ysyx_22040228div_issue_pkg;

    localparam logic [7:0] INST_DIV   = 8'h31;
    localparam logic [7:0] INST_DIVU  = 8'h32;
    localparam logic [7:0] INST_REM   = 8'h33;
    localparam logic [7:0] INST_REMU  = 8'h34;
    localparam logic [7:0] INST_DIVW  = 8'h35;
    localparam logic [7:0] INST_DIVUW = 8'h36;
    localparam logic [7:0] INST_REMW  = 8'h37;
    localparam logic [7:0] INST_REMUW = 8'h38;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SPECIAL = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } div_state_t;

    function automatic logic is_signed(input logic [7:0] op);
        return (op == INST_DIV) || (op == INST_REM) || (op == INST_DIVW) || (op == INST_REMW);
    endfunction

    function automatic logic is_word(input logic [7:0] op);
        return (op == INST_DIVW) || (op == INST_DIVUW) || (op == INST_REMW) || (op == INST_REMUW);
    endfunction

    function automatic logic is_rem(input logic [7:0] op);
        return (op == INST_REM) || (op == INST_REMU) || (op == INST_REMW) || (op == INST_REMUW);
    endfunction

endpackage

// File: rtl/ysyx_22040228div_fixup.sv
// Combinational RISC-V sign / W-variant fix-up of an unsigned divider result,
// plus divide-by-zero and signed-overflow result generation.
module ysyx_22040228div_fixup
    import ysyx_22040228div_issue_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [7:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic            neg_a,
    input  logic            neg_b,
    input  logic            div_zero,
    input  logic            sovf,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] fixed;
    logic            rem;

    always_comb begin
        rem = is_rem(op);
        if (div_zero) begin
            fixed = rem ? a : {XLEN{1'b1}};
        end else if (sovf) begin
            fixed = rem ? {XLEN{1'b0}} : a;
        end else if (rem) begin
            // remainder takes the sign of the dividend
            fixed = neg_a ? (~raw + 1'b1) : raw;
        end else begin
            fixed = (neg_a ^ neg_b) ? (~raw + 1'b1) : raw;
        end
        result = is_word(op) ? {{(XLEN-32){fixed[31]}}, fixed[31:0]} : fixed;
    end

endmodule

// File: rtl/ysyx_22040228div_issue.sv
// EX-stage issue/retire controller for the iterative divider: special cases, sign handling, stall.
// Define YSYX22040228_DIV_RESULT_CACHE_EN to add a one-entry last-result cache.
module ysyx_22040228div_issue
    import ysyx_22040228div_issue_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_div_req,
    input  logic [7:0]      ex_inst_opcode,
    input  logic [XLEN-1:0] ex_src1,
    input  logic [XLEN-1:0] ex_src2,
    input  logic            ex_flush,
    output logic            div_stall,
    output logic [XLEN-1:0] div_result,
    output logic            div_result_valid,
    output logic [XLEN-1:0] dvd_dividend,
    output logic [XLEN-1:0] dvd_diviser,
    output logic [7:0]      dvd_inst_opcode,
    output logic            dvd_ready,
    input  logic [XLEN-1:0] dvd_rem_data,
    input  logic            dvd_finish
);

    div_state_t      state_reg, state_next;
    logic [7:0]      op_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] mag_a_reg, mag_b_reg;
    logic [XLEN-1:0] result_reg;
    logic [7:0]      dvd_op_reg;
    logic            neg_a_reg, neg_b_reg, zero_reg, ovf_reg;

    logic            acc_signed, acc_word;
    logic [XLEN-1:0] ext_a, ext_b;
    logic            acc_neg_a, acc_neg_b, acc_zero, acc_ovf;
    logic            accept;
    logic            cache_hit;
    logic [XLEN-1:0] cache_result;
    logic [XLEN-1:0] fix_result;

    // Operand extension and special-case detection on the raw EX operands.
    always_comb begin
        acc_signed = is_signed(ex_inst_opcode);
        acc_word   = is_word(ex_inst_opcode);
        if (acc_word) begin
            ext_a = acc_signed ? {{(XLEN-32){ex_src1[31]}}, ex_src1[31:0]} : {{(XLEN-32){1'b0}}, ex_src1[31:0]};
            ext_b = acc_signed ? {{(XLEN-32){ex_src2[31]}}, ex_src2[31:0]} : {{(XLEN-32){1'b0}}, ex_src2[31:0]};
        end else begin
            ext_a = ex_src1;
            ext_b = ex_src2;
        end
        acc_neg_a = acc_signed & ext_a[XLEN-1];
        acc_neg_b = acc_signed & ext_b[XLEN-1];
        acc_zero  = (ext_b == {XLEN{1'b0}});
        acc_ovf   = acc_signed && (ext_b == {XLEN{1'b1}}) &&
                    (acc_word ? (ext_a == {{(XLEN-31){1'b1}}, 31'b0})
                              : (ext_a == {1'b1, {(XLEN-1){1'b0}}}));
    end

    assign accept = (state_reg == ST_IDLE) && ex_div_req && !ex_flush;

`ifdef YSYX22040228_DIV_RESULT_CACHE_EN
    logic            cache_valid_reg;
    logic [7:0]      cache_op_reg;
    logic [XLEN-1:0] cache_src1_reg, cache_src2_reg, cache_result_reg;
    logic [XLEN-1:0] src1_reg, src2_reg;

    assign cache_hit = cache_valid_reg && (cache_op_reg == ex_inst_opcode) &&
                       (cache_src1_reg == ex_src1) && (cache_src2_reg == ex_src2);
    assign cache_result = cache_result_reg;

    // Only results actually delivered to EX are remembered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid_reg  <= 1'b0;
            cache_op_reg     <= 8'd0;
            cache_src1_reg   <= '0;
            cache_src2_reg   <= '0;
            cache_result_reg <= '0;
            src1_reg         <= '0;
            src2_reg         <= '0;
        end else begin
            if (accept) begin
                src1_reg <= ex_src1;
                src2_reg <= ex_src2;
            end
            if (state_reg == ST_DONE && !ex_flush) begin
                cache_valid_reg  <= 1'b1;
                cache_op_reg     <= op_reg;
                cache_src1_reg   <= src1_reg;
                cache_src2_reg   <= src2_reg;
                cache_result_reg <= result_reg;
            end
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    ysyx_22040228div_fixup #(.XLEN(XLEN)) u_fixup (
        .op       (op_reg),
        .a        (a_reg),
        .neg_a    (neg_a_reg),
        .neg_b    (neg_b_reg),
        .div_zero (zero_reg),
        .sovf     (ovf_reg),
        .raw      (dvd_rem_data),
        .result   (fix_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        div_stall  = 1'b0;
        dvd_ready  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ex_div_req && !ex_flush) begin
                    div_stall = 1'b1;
                    if (cache_hit) begin
                        state_next = ST_DONE;
                    end else if (acc_zero || acc_ovf) begin
                        state_next = ST_SPECIAL;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_SPECIAL: begin
                div_stall  = 1'b1;
                state_next = ST_DONE;
            end
            ST_ISSUE: begin
                div_stall  = 1'b1;
                dvd_ready  = 1'b1;
                state_next = ex_flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                div_stall = 1'b1;
                // a flush racing the finish pulse means the divider is already free
                if (ex_flush && dvd_finish) begin
                    state_next = ST_IDLE;
                end else if (ex_flush) begin
                    state_next = ST_DRAIN;
                end else if (dvd_finish) begin
                    state_next = ST_DONE;
                end
            end
            ST_DRAIN: begin
                div_stall = ex_div_req;
                if (dvd_finish) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg     <= 8'd0;
            a_reg      <= '0;
            mag_a_reg  <= '0;
            mag_b_reg  <= '0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            dvd_op_reg <= 8'd0;
            result_reg <= '0;
        end else begin
            if (accept) begin
                op_reg     <= ex_inst_opcode;
                a_reg      <= ext_a;
                mag_a_reg  <= acc_neg_a ? (~ext_a + 1'b1) : ext_a;
                mag_b_reg  <= acc_neg_b ? (~ext_b + 1'b1) : ext_b;
                neg_a_reg  <= acc_neg_a;
                neg_b_reg  <= acc_neg_b;
                zero_reg   <= acc_zero;
                ovf_reg    <= acc_ovf;
                dvd_op_reg <= is_rem(ex_inst_opcode) ? INST_REMU : INST_DIVU;
            end
            if (accept && cache_hit) begin
                result_reg <= cache_result;
            end else if ((state_reg == ST_SPECIAL) ||
                         (state_reg == ST_WAIT && dvd_finish && !ex_flush)) begin
                result_reg <= fix_result;
            end
        end
    end

    assign div_result       = result_reg;
    assign div_result_valid = (state_reg == ST_DONE) && !ex_flush;
    assign dvd_dividend     = mag_a_reg;
    assign dvd_diviser      = mag_b_reg;
    assign dvd_inst_opcode  = dvd_op_reg;

endmodule

// File: tb/tb_ysyx_22040228div_issue.sv
// Randomized self-checking bench: behavioural divider plus an arithmetic RV64M reference model.
module tb_ysyx_22040228div_issue;
    import ysyx_22040228div_issue_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_div_req;
    logic [7:0]  ex_inst_opcode;
    logic [63:0] ex_src1, ex_src2;
    logic        ex_flush;
    logic        div_stall;
    logic [63:0] div_result;
    logic        div_result_valid;
    logic [63:0] dvd_dividend, dvd_diviser;
    logic [7:0]  dvd_inst_opcode;
    logic        dvd_ready;
    logic [63:0] dvd_rem_data;
    logic        dvd_finish;

    int checks = 0;
    int failures = 0;
    int ready_pulses = 0;
    int overlap_viol = 0;
    int hold_viol = 0;

    // behavioural divider state
    logic        dv_busy;
    int          dv_cnt;
    logic [63:0] dv_res, cap_a, cap_b;
    logic [7:0]  cap_op;

    // tb-side model of the optional last-result cache
    logic        mc_valid;
    logic [7:0]  mc_op;
    logic [63:0] mc_s1, mc_s2;

    ysyx_22040228div_issue dut (
        .clk              (clk),
        .rst              (rst),
        .ex_div_req       (ex_div_req),
        .ex_inst_opcode   (ex_inst_opcode),
        .ex_src1          (ex_src1),
        .ex_src2          (ex_src2),
        .ex_flush         (ex_flush),
        .div_stall        (div_stall),
        .div_result       (div_result),
        .div_result_valid (div_result_valid),
        .dvd_dividend     (dvd_dividend),
        .dvd_diviser      (dvd_diviser),
        .dvd_inst_opcode  (dvd_inst_opcode),
        .dvd_ready        (dvd_ready),
        .dvd_rem_data     (dvd_rem_data),
        .dvd_finish       (dvd_finish)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider: starts on the edge sampling dvd_ready, pulses finish 65 edges later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_busy      <= 1'b0;
            dv_cnt       <= 0;
            dv_res       <= '0;
            dvd_finish   <= 1'b0;
            dvd_rem_data <= '0;
        end else begin
            dvd_finish <= 1'b0;
            if (dvd_ready) begin
                ready_pulses <= ready_pulses + 1;
                if (dv_busy) overlap_viol <= overlap_viol + 1;
                dv_busy <= 1'b1;
                dv_cnt  <= 64;
                cap_a   <= dvd_dividend;
                cap_b   <= dvd_diviser;
                cap_op  <= dvd_inst_opcode;
                dv_res  <= (dvd_inst_opcode == INST_REMU) ? dvd_dividend % dvd_diviser
                                                         : dvd_dividend / dvd_diviser;
            end else if (dv_busy) begin
                if (dvd_dividend !== cap_a || dvd_diviser !== cap_b || dvd_inst_opcode !== cap_op)
                    hold_viol <= hold_viol + 1;
                if (dv_cnt == 0) begin
                    dvd_finish   <= 1'b1;
                    dvd_rem_data <= dv_res;
                    dv_busy      <= 1'b0;
                end else begin
                    dv_cnt <= dv_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // RV64M semantics straight from the ISA rules.
    function automatic logic [63:0] ref_div(input logic [7:0] op, input logic [63:0] s1, input logic [63:0] s2);
        longint sa, sb;
        int wa, wb;
        logic [31:0] ua, ub, r32;
        sa = s1; sb = s2;
        ua = s1[31:0]; ub = s2[31:0];
        wa = ua; wb = ub;
        case (op)
            INST_DIV: begin
                if (s2 == 0) return '1;
                if (s1 == 64'h8000_0000_0000_0000 && s2 == '1) return s1;
                return sa / sb;
            end
            INST_DIVU: return (s2 == 0) ? '1 : s1 / s2;
            INST_REM: begin
                if (s2 == 0) return s1;
                if (s1 == 64'h8000_0000_0000_0000 && s2 == '1) return '0;
                return sa % sb;
            end
            INST_REMU: return (s2 == 0) ? s1 : s1 % s2;
            INST_DIVW: begin
                if (ub == 0) return '1;
                if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sext32(ua);
                r32 = wa / wb;
                return sext32(r32);
            end
            INST_DIVUW: begin
                if (ub == 0) return '1;
                r32 = ua / ub;
                return sext32(r32);
            end
            INST_REMW: begin
                if (ub == 0) return sext32(ua);
                if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return '0;
                r32 = wa % wb;
                return sext32(r32);
            end
            default: begin
                if (ub == 0) return sext32(ua);
                r32 = ua % ub;
                return sext32(r32);
            end
        endcase
    endfunction

    function automatic bit ref_special(input logic [7:0] op, input logic [63:0] s1, input logic [63:0] s2);
        bit w, sg;
        w  = op inside {INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
        sg = op inside {INST_DIV, INST_REM, INST_DIVW, INST_REMW};
        if (w) return (s2[31:0] == 0) || (sg && s1[31:0] == 32'h8000_0000 && s2[31:0] == 32'hFFFF_FFFF);
        return (s2 == 0) || (sg && s1 == 64'h8000_0000_0000_0000 && s2 == '1);
    endfunction

    function automatic logic [63:0] rand_operand();
        longint v;
        case ($urandom_range(0, 5))
            0: begin v = longint'($urandom_range(0, 40)); return v - 20; end
            1: return {$urandom, $urandom};
            2: return '0;
            3: return '1;
            4: return 64'h8000_0000_0000_0000;
            default: return 64'h0000_0000_8000_0000;
        endcase
    endfunction

    // Present one op at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
    task automatic run_op(input logic [7:0] op, input logic [63:0] s1, input logic [63:0] s2, input string tag);
        int c, r0, exp_lat, exp_rdy;
        bit stall_bad;
        logic [63:0] exp;
        exp     = ref_div(op, s1, s2);
        exp_lat = ref_special(op, s1, s2) ? 2 : 68;
        exp_rdy = ref_special(op, s1, s2) ? 0 : 1;
`ifdef YSYX22040228_DIV_RESULT_CACHE_EN
        if (mc_valid && mc_op == op && mc_s1 == s1 && mc_s2 == s2) begin
            exp_lat = 1;
            exp_rdy = 0;
        end
`endif
        ex_inst_opcode = op; ex_src1 = s1; ex_src2 = s2; ex_div_req = 1'b1;
        r0 = ready_pulses;
        @(posedge clk); #1;
        c = 1; stall_bad = 0;
        while (!div_result_valid && c < 200) begin
            if (!div_stall) stall_bad = 1;
            @(posedge clk); #1;
            c++;
        end
        check({tag, " valid"}, 64'(div_result_valid), 64'd1);
        check({tag, " result"}, div_result, exp);
        check({tag, " done_stall"}, 64'(div_stall), 64'd0);
        check({tag, " latency"}, 64'(c), 64'(exp_lat));
        check({tag, " stall_high"}, 64'(stall_bad), 64'd0);
        ex_div_req = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready_pulses"}, 64'(ready_pulses - r0), 64'(exp_rdy));
        mc_valid = 1'b1; mc_op = op; mc_s1 = s1; mc_s2 = s2;
    endtask

    initial begin
        logic [7:0] ops [8];
        int c, nvalid;
        bit stall_bad;
        logic [63:0] first_res;
        ops = '{INST_DIV, INST_DIVU, INST_REM, INST_REMU, INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
        mc_valid = 1'b0; mc_op = '0; mc_s1 = '0; mc_s2 = '0;
        rst = 1'b1; ex_div_req = 1'b0; ex_inst_opcode = '0; ex_src1 = '0; ex_src2 = '0; ex_flush = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("reset stall", 64'(div_stall), 64'd0);
        check("reset result", div_result, 64'd0);
        check("reset valid", 64'(div_result_valid), 64'd0);
        check("reset dvd_op", 64'(dvd_inst_opcode), 64'd0);
        check("reset dvd_ready", 64'(dvd_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        run_op(INST_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "div_m7_2");
        check("div_m7_2 dvd_a", cap_a, 64'd7);
        check("div_m7_2 dvd_b", cap_b, 64'd2);
        check("div_m7_2 dvd_op", 64'(cap_op), 64'(INST_DIVU));
        run_op(INST_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "rem_m7_2");
        check("rem_m7_2 dvd_op", 64'(cap_op), 64'(INST_REMU));
        run_op(INST_REMU, 64'd7, 64'd0, "remu_7_0");
        run_op(INST_DIV, 64'h8000_0000_0000_0000, '1, "div_ovf");
        run_op(INST_DIVW, 64'h0000_0000_8000_0000, '1, "divw_ovf");
        run_op(INST_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, "divuw_zext");

        // flush 10 cycles into WAIT, next op queued behind the draining divider
        ex_inst_opcode = INST_DIVU; ex_src1 = 64'd1000; ex_src2 = 64'd3; ex_div_req = 1'b1;
        @(posedge clk);
        repeat (11) @(posedge clk);
        #1;
        ex_flush = 1'b1; ex_src1 = 64'd100; ex_src2 = 64'd7;
        @(posedge clk); #1;
        ex_flush = 1'b0;
        c = 0; nvalid = 0; stall_bad = 0; first_res = '0;
        while (nvalid == 0 && c < 300) begin
            if (div_result_valid) begin
                nvalid = 1;
                first_res = div_result;
            end else begin
                if (!div_stall) stall_bad = 1;
                @(posedge clk); #1;
                c++;
            end
        end
        check("flush new_valid", 64'(nvalid), 64'd1);
        check("flush new_result", first_res, 64'd14);
        check("flush stall_high", 64'(stall_bad), 64'd0);
        ex_div_req = 1'b0;
        @(posedge clk); #1;
        mc_valid = 1'b1; mc_op = INST_DIVU; mc_s1 = 64'd100; mc_s2 = 64'd7;

        for (int i = 0; i < 24; i++) begin
            run_op(ops[$urandom_range(0, 7)], rand_operand(), rand_operand(), $sformatf("rnd%0d", i));
        end

        // asynchronous reset in the middle of WAIT
        ex_inst_opcode = INST_DIVU; ex_src1 = 64'd5000; ex_src2 = 64'd9; ex_div_req = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0; ex_div_req = 1'b0;
        #1;
        check("midreset stall", 64'(div_stall), 64'd0);
        check("midreset result", div_result, 64'd0);
        check("midreset valid", 64'(div_result_valid), 64'd0);
        check("midreset dvd_a", dvd_dividend, 64'd0);
        check("midreset dvd_b", dvd_diviser, 64'd0);
        check("midreset dvd_op", 64'(dvd_inst_opcode), 64'd0);
        check("midreset dvd_ready", 64'(dvd_ready), 64'd0);
        mc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        run_op(INST_DIVU, 64'd123, 64'd10, "repeat_a");
        run_op(INST_DIVU, 64'd123, 64'd10, "repeat_b");

        check("divider overlap", 64'(overlap_viol), 64'd0);
        check("divider operand hold", 64'(hold_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
